// File: rtl/explored_insert.sv
// Inserts a node into the explored-set RAM: scans slots from 0 for a free or matching node_id.
// Optional macro EXPLORED_UPDATE_COST_EN: a cheaper duplicate overwrites the stored node.
module explored_insert #(
  parameter int unsigned MAX_NODES = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         insert,
  input  logic [271:0] new_node,
  input  logic [271:0] read_node,
  output logic [8:0]   read_address,
  output logic         write_enable,
  output logic [8:0]   write_address,
  output logic [271:0] write_data,
  output logic         busy,
  output logic         inserted,
  output logic         duplicate,
  output logic         full,
  output logic         done
);

  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned NODE_W   = 272;
  localparam int unsigned FIELD_W  = 16;
  localparam int unsigned ID_LSB   = 224;
  localparam int unsigned COST_LSB = 192;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_NODES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_READ,
    READ,
    SET_ADDRESS,
    WRITE,
    DONE
  } state_t;

  state_t              state, state_d;
  logic [NODE_W-1:0]   node_q, node_d;
  logic [ADDR_W-1:0]   read_address_d, write_address_d;
  logic [NODE_W-1:0]   write_data_d;
  logic                write_enable_d, busy_d, done_d;
  logic                inserted_d, duplicate_d, full_d;

  logic [FIELD_W-1:0]  new_id, node_id, slot_id;
  logic [FIELD_W-1:0]  node_cost, slot_cost;
  logic                unused_read_bits;

  assign new_id    = new_node[ID_LSB +: FIELD_W];
  assign node_id   = node_q[ID_LSB +: FIELD_W];
  assign node_cost = node_q[COST_LSB +: FIELD_W];
  assign slot_id   = read_node[ID_LSB +: FIELD_W];
  assign slot_cost = read_node[COST_LSB +: FIELD_W];
  assign unused_read_bits = ^{read_node, node_cost, slot_cost};

  // Next state and next values of every registered output.
  always_comb begin
    state_d         = state;
    node_d          = node_q;
    read_address_d  = read_address;
    write_address_d = write_address;
    write_data_d    = write_data;
    inserted_d      = inserted;
    duplicate_d     = duplicate;
    full_d          = full;

    case (state)
      IDLE: begin
        if (insert) state_d = START;
      end
      START: begin
        node_d         = new_node;
        read_address_d = '0;
        inserted_d     = 1'b0;
        duplicate_d    = 1'b0;
        full_d         = 1'b0;
        state_d        = (new_id == '0) ? DONE : WAIT_READ;
      end
      WAIT_READ: begin
        state_d = READ;
      end
      READ: begin
        if (slot_id == node_id) begin
          duplicate_d = 1'b1;
          state_d     = DONE;
`ifdef EXPLORED_UPDATE_COST_EN
          if (node_cost < slot_cost) begin
            state_d         = WRITE;
            write_address_d = read_address;
            write_data_d    = node_q;
          end
`endif
        end else if (slot_id == '0) begin
          state_d         = WRITE;
          write_address_d = read_address;
          write_data_d    = node_q;
        end else if (read_address < LAST_ADDR) begin
          state_d = SET_ADDRESS;
        end else begin
          // Full scan drains through SET_ADDRESS with the address held at its limit.
          full_d  = 1'b1;
          state_d = SET_ADDRESS;
        end
      end
      SET_ADDRESS: begin
        if (full) begin
          state_d = DONE;
        end else begin
          read_address_d = ADDR_W'(read_address + ADDR_W'(1));
          state_d        = WAIT_READ;
        end
      end
      WRITE: begin
        inserted_d = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    write_enable_d = (state_d == WRITE);
    done_d         = (state_d == DONE);
    busy_d         = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      node_q        <= '0;
      read_address  <= '0;
      write_address <= '0;
      write_data    <= '0;
      write_enable  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      inserted      <= 1'b0;
      duplicate     <= 1'b0;
      full          <= 1'b0;
    end else begin
      state         <= state_d;
      node_q        <= node_d;
      read_address  <= read_address_d;
      write_address <= write_address_d;
      write_data    <= write_data_d;
      write_enable  <= write_enable_d;
      busy          <= busy_d;
      done          <= done_d;
      inserted      <= inserted_d;
      duplicate     <= duplicate_d;
      full          <= full_d;
    end
  end

endmodule

// File: tb/tb_explored_insert.sv
// Directed bench for explored_insert with a 4-slot RAM model; cycle counts are relative to insert acceptance.
module tb_explored_insert;

  logic         clk;
  logic         reset;
  logic         insert;
  logic [271:0] new_node;
  logic [271:0] read_node;
  logic [8:0]   read_address;
  logic         write_enable;
  logic [8:0]   write_address;
  logic [271:0] write_data;
  logic         busy, inserted, duplicate, full, done;

  int vectors;
  int miscompares;

  logic [271:0] mem [0:3];
  logic         ld_en;
  logic [1:0]   ld_addr;
  logic [271:0] ld_data;

  explored_insert #(.MAX_NODES(4)) dut (
    .clk(clk), .reset(reset), .insert(insert), .new_node(new_node),
    .read_node(read_node), .read_address(read_address),
    .write_enable(write_enable), .write_address(write_address),
    .write_data(write_data), .busy(busy), .inserted(inserted),
    .duplicate(duplicate), .full(full), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Explored RAM: 1-cycle registered read, bench preload port takes priority.
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (write_enable && write_address < 9'd4) mem[write_address[1:0]] <= write_data;
    read_node <= (read_address < 9'd4) ? mem[read_address[1:0]] : '0;
  end

  function automatic logic [271:0] make_node(input logic [15:0] id, input logic [15:0] cost);
    logic [271:0] n;
    n = {17{16'h5A3C}};
    n[239:224] = id;
    n[207:192] = cost;
    return n;
  endfunction

  task automatic load_slot(input int a, input logic [271:0] d);
    ld_en = 1'b1; ld_addr = 2'(a); ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic load_ram(input logic [271:0] d0, input logic [271:0] d1,
                          input logic [271:0] d2, input logic [271:0] d3);
    load_slot(0, d0); load_slot(1, d1); load_slot(2, d2); load_slot(3, d3);
  endtask

  // Drives one insert from IDLE and observes until done; leaves the DUT back in IDLE.
  task automatic run_insert(input logic [271:0] node, output int we_c, output int done_c,
                            output int nw, output int wa, output int max_ra);
    new_node = node;
    insert = 1'b1;
    @(posedge clk); #1;
    insert = 1'b0;
    we_c = -1; done_c = -1; nw = 0; wa = -1; max_ra = 0;
    for (int c = 1; c <= 60; c++) begin
      if (int'(read_address) > max_ra) max_ra = int'(read_address);
      if (write_enable) begin nw++; we_c = c; wa = int'(write_address); end
      if (done) begin done_c = c; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (read_address !== 9'd0) begin miscompares++; $display("FAIL reset_read_address: got %0d expected 0", read_address); end
    vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL reset_write_enable: got %b expected 0", write_enable); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (inserted !== 1'b0) begin miscompares++; $display("FAIL reset_inserted: got %b expected 0", inserted); end
    vectors++; if (duplicate !== 1'b0) begin miscompares++; $display("FAIL reset_duplicate: got %b expected 0", duplicate); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b expected 0", full); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_empty_insert();
    int we_c, done_c, nw, wa, max_ra;
    logic [271:0] exp;
    exp = make_node(16'd5, 16'd10);
    load_ram('0, '0, '0, '0);
    run_insert(exp, we_c, done_c, nw, wa, max_ra);
    vectors++; if (we_c !== 4) begin miscompares++; $display("FAIL empty_we_cycle: got %0d expected 4", we_c); end
    vectors++; if (wa !== 0) begin miscompares++; $display("FAIL empty_write_address: got %0d expected 0", wa); end
    vectors++; if (done_c !== 5) begin miscompares++; $display("FAIL empty_done_cycle: got %0d expected 5", done_c); end
    vectors++; if (nw !== 1) begin miscompares++; $display("FAIL empty_write_count: got %0d expected 1", nw); end
    vectors++; if (mem[0] !== exp) begin miscompares++; $display("FAIL empty_ram_slot0: got %h expected %h", mem[0], exp); end
    // Status is sampled one cycle after done, so this also covers holding in IDLE.
    vectors++; if (inserted !== 1'b1) begin miscompares++; $display("FAIL empty_inserted: got %b expected 1", inserted); end
    vectors++; if (duplicate !== 1'b0) begin miscompares++; $display("FAIL empty_duplicate: got %b expected 0", duplicate); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL empty_full: got %b expected 0", full); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL empty_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_scan_hit();
    int we_c, done_c, nw, wa, max_ra;
    load_ram(make_node(16'd3, 16'd1), make_node(16'd7, 16'd1), make_node(16'd9, 16'd1), '0);
    run_insert(make_node(16'd4, 16'd2), we_c, done_c, nw, wa, max_ra);
    vectors++; if (we_c !== 13) begin miscompares++; $display("FAIL scan_we_cycle: got %0d expected 13", we_c); end
    vectors++; if (wa !== 3) begin miscompares++; $display("FAIL scan_write_address: got %0d expected 3", wa); end
    vectors++; if (done_c !== 14) begin miscompares++; $display("FAIL scan_done_cycle: got %0d expected 14", done_c); end
    vectors++; if (inserted !== 1'b1) begin miscompares++; $display("FAIL scan_inserted: got %b expected 1", inserted); end
    vectors++; if (mem[3][239:224] !== 16'd4) begin miscompares++; $display("FAIL scan_ram_slot3_id: got %0d expected 4", mem[3][239:224]); end
  endtask

  task automatic test_duplicate();
    int we_c, done_c, nw, wa, max_ra;
    int exp_nw, exp_done;
    logic exp_ins;
    load_ram(make_node(16'd3, 16'd1), make_node(16'd7, 16'd20), '0, '0);
    run_insert(make_node(16'd7, 16'd15), we_c, done_c, nw, wa, max_ra);
`ifdef EXPLORED_UPDATE_COST_EN
    exp_nw = 1; exp_done = 8; exp_ins = 1'b1;
    vectors++; if (wa !== 1) begin miscompares++; $display("FAIL dup_cheaper_write_address: got %0d expected 1", wa); end
    vectors++; if (mem[1][207:192] !== 16'd15) begin miscompares++; $display("FAIL dup_cheaper_ram_cost: got %0d expected 15", mem[1][207:192]); end
`else
    exp_nw = 0; exp_done = 7; exp_ins = 1'b0;
    vectors++; if (mem[1][207:192] !== 16'd20) begin miscompares++; $display("FAIL dup_cheaper_ram_cost: got %0d expected 20", mem[1][207:192]); end
`endif
    vectors++; if (nw !== exp_nw) begin miscompares++; $display("FAIL dup_cheaper_write_count: got %0d expected %0d", nw, exp_nw); end
    vectors++; if (done_c !== exp_done) begin miscompares++; $display("FAIL dup_cheaper_done_cycle: got %0d expected %0d", done_c, exp_done); end
    vectors++; if (inserted !== exp_ins) begin miscompares++; $display("FAIL dup_cheaper_inserted: got %b expected %b", inserted, exp_ins); end
    vectors++; if (duplicate !== 1'b1) begin miscompares++; $display("FAIL dup_cheaper_duplicate: got %b expected 1", duplicate); end

    load_slot(1, make_node(16'd7, 16'd20));
    run_insert(make_node(16'd7, 16'd25), we_c, done_c, nw, wa, max_ra);
    vectors++; if (nw !== 0) begin miscompares++; $display("FAIL dup_costlier_write_count: got %0d expected 0", nw); end
    vectors++; if (done_c !== 7) begin miscompares++; $display("FAIL dup_costlier_done_cycle: got %0d expected 7", done_c); end
    vectors++; if (inserted !== 1'b0) begin miscompares++; $display("FAIL dup_costlier_inserted: got %b expected 0", inserted); end
    vectors++; if (duplicate !== 1'b1) begin miscompares++; $display("FAIL dup_costlier_duplicate: got %b expected 1", duplicate); end
  endtask

  task automatic test_full();
    int we_c, done_c, nw, wa, max_ra;
    load_ram(make_node(16'd1, 16'd1), make_node(16'd2, 16'd1), make_node(16'd3, 16'd1), make_node(16'd6, 16'd1));
    run_insert(make_node(16'd8, 16'd1), we_c, done_c, nw, wa, max_ra);
    vectors++; if (nw !== 0) begin miscompares++; $display("FAIL full_write_count: got %0d expected 0", nw); end
    vectors++; if (done_c !== 14) begin miscompares++; $display("FAIL full_done_cycle: got %0d expected 14", done_c); end
    vectors++; if (max_ra !== 3) begin miscompares++; $display("FAIL full_max_read_address: got %0d expected 3", max_ra); end
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_flag: got %b expected 1", full); end
    vectors++; if (inserted !== 1'b0) begin miscompares++; $display("FAIL full_inserted: got %b expected 0", inserted); end
    vectors++; if (duplicate !== 1'b0) begin miscompares++; $display("FAIL full_duplicate: got %b expected 0", duplicate); end
  endtask

  task automatic test_zero_node();
    int we_c, done_c, nw, wa, max_ra;
    run_insert(make_node(16'd0, 16'd9), we_c, done_c, nw, wa, max_ra);
    vectors++; if (done_c !== 2) begin miscompares++; $display("FAIL zero_done_cycle: got %0d expected 2", done_c); end
    vectors++; if (nw !== 0) begin miscompares++; $display("FAIL zero_write_count: got %0d expected 0", nw); end
    vectors++; if ({inserted, duplicate, full} !== 3'b000) begin miscompares++; $display("FAIL zero_status: got %b expected 000", {inserted, duplicate, full}); end
  endtask

  task automatic test_back_to_back();
    int first_done, second_done, c;
    load_ram('0, '0, '0, '0);
    new_node = make_node(16'd5, 16'd10);
    insert = 1'b1;
    @(posedge clk); #1;
    first_done = -1; second_done = -1;
    for (c = 1; c <= 20; c++) begin
      if (done) begin first_done = c; break; end
      @(posedge clk); #1;
    end
    vectors++; if (first_done !== 5) begin miscompares++; $display("FAIL b2b_first_done: got %0d expected 5", first_done); end
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept_busy: got %b expected 1", busy); end
    insert = 1'b0;
    for (c = 7; c <= 40; c++) begin
      if (done) begin second_done = c; break; end
      @(posedge clk); #1;
    end
    vectors++; if (second_done !== 10) begin miscompares++; $display("FAIL b2b_second_done: got %0d expected 10", second_done); end
    vectors++; if (duplicate !== 1'b1) begin miscompares++; $display("FAIL b2b_duplicate: got %b expected 1", duplicate); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_before_write();
    int nw;
    load_ram('0, '0, '0, '0);
    new_node = make_node(16'd5, 16'd10);
    insert = 1'b1;
    @(posedge clk); #1;
    insert = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++; if ({write_enable, busy, done, inserted, duplicate, full} !== 6'b0) begin miscompares++; $display("FAIL rst_mid_outputs: got %b expected 000000", {write_enable, busy, done, inserted, duplicate, full}); end
    vectors++; if (read_address !== 9'd0) begin miscompares++; $display("FAIL rst_mid_read_address: got %0d expected 0", read_address); end
    nw = 0;
    repeat (20) begin
      if (write_enable) nw++;
      @(posedge clk); #1;
    end
    vectors++; if (nw !== 0) begin miscompares++; $display("FAIL rst_mid_write_count: got %0d expected 0", nw); end
    vectors++; if (mem[0] !== 272'b0) begin miscompares++; $display("FAIL rst_mid_ram_slot0: got %h expected 0", mem[0]); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; insert = 1'b0; new_node = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    test_reset();
    test_empty_insert();
    test_scan_hit();
    test_duplicate();
    test_full();
    test_zero_node();
    test_back_to_back();
    test_reset_before_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
